// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg: state encoding and sizing helpers for the sequence detector. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEF_MAXLEN = 8;

  // Smallest cfg_len width able to hold the value MAXLEN itself.
  function automatic int len_w(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_core.sv
// ---------------------------------------------------------------------------
// seq_match_core: history shift register, fill counter and Mealy pattern compare. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int LEN_W  = len_w(MAXLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic              din_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [MAXLEN-1:0] pattern_i,
  input  logic              overlap_i,
  output logic              match_o
);

  localparam logic [LEN_W:0] ONE = 1;

  logic [MAXLEN-1:0] hist_q, hist_d, mask;
  logic [LEN_W-1:0]  fill_q, fill_d;
  logic [LEN_W:0]    fill_inc;
  logic              full;

  always_comb begin
    hist_d   = {hist_q[MAXLEN-2:0], din_i};
    fill_inc = {1'b0, fill_q} + ONE;
    full     = (fill_inc >= {1'b0, len_i});
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (i < int'(len_i));
    end
    match_o = accept_i && full && (((hist_d ^ pattern_i) & mask) == '0);

    // Non-overlapping mode discards the history consumed by a match.
    fill_d = fill_q;
    if (accept_i) begin
      if (match_o && !overlap_i) fill_d = '0;
      else if (full)             fill_d = len_i;
      else                       fill_d = fill_inc[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (accept_i) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl: programmable serial sequence-detector controller (FSM, config, counter). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = len_w(MAXLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [MAXLEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic              cfg_overlap_i,
  input  logic [CNT_W-1:0]  cfg_target_i,
  input  logic              din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  output logic              match_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o,
  output logic [1:0]        state_out_o
);

  localparam logic [CNT_W:0] ONE = 1;

  state_e            state_q;
  logic              busy_q, done_q, cfg_err_q;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d, tgt_q;
  logic [MAXLEN-1:0] pat_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovl_q;
  logic [CNT_W:0]    cnt_p1;
  logic              len_ok, launch, accept, match, hit_tgt;

  assign din_ready_o = (state_q == ST_RUN);
  assign accept      = din_valid_i && din_ready_o;
  assign len_ok      = (cfg_len_i != '0) && (int'(cfg_len_i) <= MAXLEN);
  assign launch      = (state_q == ST_IDLE) && start_i && !abort_i && len_ok;

  assign cnt_p1      = {1'b0, match_cnt_q} + ONE;
  assign match_cnt_d = (&match_cnt_q) ? match_cnt_q : cnt_p1[CNT_W-1:0];
  assign hit_tgt     = (tgt_q != '0) && (cnt_p1 == {1'b0, tgt_q});

  seq_match_core #(
    .MAXLEN (MAXLEN),
    .LEN_W  (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (launch),
    .accept_i  (accept),
    .din_i     (din_i),
    .len_i     (len_q),
    .pattern_i (pat_q),
    .overlap_i (ovl_q),
    .match_o   (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      match_cnt_q <= '0;
      tgt_q       <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            if (len_ok) begin
              pat_q       <= cfg_pattern_i;
              len_q       <= cfg_len_i;
              ovl_q       <= cfg_overlap_i;
              tgt_q       <= cfg_target_i;
              match_cnt_q <= '0;
              state_q     <= ST_RUN;
              busy_q      <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A bit accepted alongside abort still counts.
          if (match) match_cnt_q <= match_cnt_d;
          if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (match && hit_tgt) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (abort_i || start_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign match_o     = match;
  assign match_cnt_o = match_cnt_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;
  assign state_out_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_det_ctrl: table-driven, scoreboarded bench for seq_det_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, abort_i;
  logic [7:0] cfg_pattern_i;
  logic [3:0] cfg_len_i;
  logic       cfg_overlap_i;
  logic [7:0] cfg_target_i;
  logic       din_i, din_valid_i;
  logic       din_ready_o, match_o, busy_o, done_o, cfg_err_o;
  logic [7:0] match_cnt_o;
  logic [1:0] state_out_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       din;
    logic       vld;
    logic       rdy;
    logic       m;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[30];
  vec_t sb[$];

  seq_det_ctrl #(.MAXLEN(8), .CNT_W(8), .LEN_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .cfg_pattern_i (cfg_pattern_i),
    .cfg_len_i     (cfg_len_i),
    .cfg_overlap_i (cfg_overlap_i),
    .cfg_target_i  (cfg_target_i),
    .din_i         (din_i),
    .din_valid_i   (din_valid_i),
    .din_ready_o   (din_ready_o),
    .match_o       (match_o),
    .match_cnt_o   (match_cnt_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cfg_err_o     (cfg_err_o),
    .state_out_o   (state_out_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic [7:0] tgt);
    start_i = 1'b1; cfg_pattern_i = pat; cfg_len_i = len;
    cfg_overlap_i = ovl; cfg_target_i = tgt;
    next_cycle();
    start_i = 1'b0;
    chk("start_state", int'(state_out_o), 1);
    chk("start_busy", int'(busy_o), 1);
    chk("start_cnt", int'(match_cnt_o), 0);
  endtask

  task automatic do_abort(input int exp_cnt);
    abort_i = 1'b1;
    next_cycle();
    abort_i = 1'b0;
    chk("abort_state", int'(state_out_o), 0);
    chk("abort_cnt_held", int'(match_cnt_o), exp_cnt);
  endtask

  task automatic apply(input int lo, input int hi);
    vec_t e;
    for (int i = lo; i <= hi; i++) begin
      din_i = vecs[i].din;
      din_valid_i = vecs[i].vld;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("match[%0d]", i), int'(match_o), int'(e.m));
      chk($sformatf("ready[%0d]", i), int'(din_ready_o), int'(e.rdy));
      next_cycle();
      chk($sformatf("cnt[%0d]", i), int'(match_cnt_o), int'(e.cnt));
    end
    din_valid_i = 1'b0;
  endtask

  initial begin
    // 101, overlap: matches on bits 3 and 5
    vecs[0]  = '{1, 1, 1, 0, 8'd0}; vecs[1]  = '{0, 1, 1, 0, 8'd0};
    vecs[2]  = '{1, 1, 1, 1, 8'd1}; vecs[3]  = '{0, 1, 1, 0, 8'd1};
    vecs[4]  = '{1, 1, 1, 1, 8'd2};
    // 101, no overlap: only bit 3 matches
    vecs[5]  = '{1, 1, 1, 0, 8'd0}; vecs[6]  = '{0, 1, 1, 0, 8'd0};
    vecs[7]  = '{1, 1, 1, 1, 8'd1}; vecs[8]  = '{0, 1, 1, 0, 8'd1};
    vecs[9]  = '{1, 1, 1, 0, 8'd1};
    // target 2: bit 6 is offered after DONE and refused
    vecs[10] = '{1, 1, 1, 0, 8'd0}; vecs[11] = '{0, 1, 1, 0, 8'd0};
    vecs[12] = '{1, 1, 1, 1, 8'd1}; vecs[13] = '{0, 1, 1, 0, 8'd1};
    vecs[14] = '{1, 1, 1, 1, 8'd2}; vecs[15] = '{1, 1, 0, 0, 8'd2};
    // gaps in the valid stream
    vecs[16] = '{1, 1, 1, 0, 8'd0}; vecs[17] = '{1, 0, 1, 0, 8'd0};
    vecs[18] = '{0, 1, 1, 0, 8'd0}; vecs[19] = '{1, 0, 1, 0, 8'd0};
    vecs[20] = '{1, 0, 1, 0, 8'd0}; vecs[21] = '{1, 1, 1, 1, 8'd1};
    // 1,0,1,1,0 before abort
    vecs[22] = '{1, 1, 1, 0, 8'd0}; vecs[23] = '{0, 1, 1, 0, 8'd0};
    vecs[24] = '{1, 1, 1, 1, 8'd1}; vecs[25] = '{1, 1, 1, 0, 8'd1};
    vecs[26] = '{0, 1, 1, 0, 8'd1};
    // len=1, pattern bit 1, no overlap
    vecs[27] = '{1, 1, 1, 1, 8'd1}; vecs[28] = '{0, 1, 1, 0, 8'd1};
    vecs[29] = '{1, 1, 1, 1, 8'd2};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    cfg_pattern_i = '0; cfg_len_i = '0; cfg_overlap_i = 1'b0; cfg_target_i = '0;
    din_i = 1'b0; din_valid_i = 1'b0;
    repeat (2) next_cycle();
    chk("rst_state", int'(state_out_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_cnt", int'(match_cnt_o), 0);
    chk("rst_ready", int'(din_ready_o), 0);
    rst_n = 1'b1;
    next_cycle();

    do_start(8'b101, 4'd3, 1'b1, 8'd0);
    apply(0, 4);
    chk("t1_busy", int'(busy_o), 1);
    do_abort(2);

    do_start(8'b101, 4'd3, 1'b0, 8'd0);
    apply(5, 9);
    do_abort(1);

    do_start(8'b101, 4'd3, 1'b1, 8'd2);
    apply(10, 15);
    chk("t3_done", int'(done_o), 1);
    chk("t3_state", int'(state_out_o), 2);
    chk("t3_busy", int'(busy_o), 0);
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    chk("done_start_idle", int'(state_out_o), 0);
    chk("done_start_norelaunch", int'(busy_o), 0);
    chk("done_cleared", int'(done_o), 0);

    start_i = 1'b1; cfg_len_i = 4'd0;
    next_cycle();
    start_i = 1'b0;
    chk("len0_err", int'(cfg_err_o), 1);
    chk("len0_state", int'(state_out_o), 0);
    chk("len0_ready", int'(din_ready_o), 0);
    next_cycle();
    chk("len0_err_pulse", int'(cfg_err_o), 0);
    start_i = 1'b1; cfg_len_i = 4'd9;
    next_cycle();
    start_i = 1'b0;
    chk("len9_err", int'(cfg_err_o), 1);
    chk("len9_state", int'(state_out_o), 0);
    next_cycle();
    chk("len9_err_pulse", int'(cfg_err_o), 0);
    chk("len9_ready", int'(din_ready_o), 0);

    do_start(8'b101, 4'd3, 1'b1, 8'd0);
    apply(16, 21);
    do_abort(1);

    do_start(8'b101, 4'd3, 1'b1, 8'd0);
    apply(22, 26);
    abort_i = 1'b1; din_i = 1'b1; din_valid_i = 1'b1;
    @(negedge clk);
    chk("abort_cycle_match", int'(match_o), 1);
    next_cycle();
    abort_i = 1'b0; din_valid_i = 1'b0;
    chk("abort_cycle_state", int'(state_out_o), 0);
    chk("abort_cycle_cnt", int'(match_cnt_o), 2);
    next_cycle();
    chk("abort_idle_cnt_held", int'(match_cnt_o), 2);

    do_start(8'h01, 4'd1, 1'b0, 8'd0);
    apply(27, 29);
    din_i = 1'b1; din_valid_i = 1'b1;
    #1;
    chk("pre_rst_match", int'(match_o), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state_out_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_cnt", int'(match_cnt_o), 0);
    chk("async_rst_ready", int'(din_ready_o), 0);
    chk("async_rst_match", int'(match_o), 0);
    din_valid_i = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial sequence-detector controller. It sequences a Mealy-style pattern detector over a handshaked 1-bit input stream. Pattern, length, overlap mode and target match count are latched on start. It counts matches, stops the stream when the target is reached, and exposes its state for debug in the same way the fixed detectors expose PS_out.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target count
LEN_W, 4, width of cfg_len; must satisfy 2**LEN_W > MAXLEN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  single-cycle request to latch config and begin; honoured only in IDLE
abort  input  1  return to IDLE from any non-IDLE state next cycle
cfg_pattern  input  MAXLEN  pattern; bit [cfg_len-1] is the first bit received
cfg_len  input  LEN_W  pattern length, legal 1..MAXLEN
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  matches before DONE; 0 = run until abort
din  input  1  serial data bit
din_valid  input  1  din is valid
din_ready  output  1  controller accepts din (bit accepted when valid&ready)
match  output  1  Mealy pulse, high in the cycle the completing bit is accepted
match_cnt  output  CNT_W  matches in current run
busy  output  1  state == RUN
done  output  1  state == DONE
cfg_err  output  1  one-cycle pulse, illegal cfg_len at start
state_out  output  2  current state encoding

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; history, fill count and match_cnt are 0; all outputs 0 (state_out=2'b00).
- States: IDLE=00, RUN=01, DONE=10; 11 is unused and recovers to IDLE.
- IDLE transitions on start:
  - cfg_len in 1..MAXLEN: latch all cfg_* inputs, clear history, fill and match_cnt, go to RUN next cycle.
  - Otherwise: cfg_err=1 for one cycle, stay IDLE.
- cfg_* inputs are ignored outside IDLE.
- din_ready = (state==RUN). Combinational from state only; it never depends on din_valid.
- Each accepted bit:
  - hist_next = {hist[MAXLEN-2:0], din}
  - fill_next = min(fill+1, len)
  - match = (fill+1 >= len) && (hist_next[len-1:0] == pattern[len-1:0]); combinational in the same cycle.
- On match:
  - match_cnt increments, saturating at all-ones.
  - If cfg_overlap=0: fill clears to 0 (history bits are unusable for the next match).
  - If cfg_overlap=1: fill stays at len.
- Target reached: if target!=0 and match_cnt+1==target on a match, go to DONE next cycle. match is still asserted in that cycle.
- Cycles without an accepted bit: no history, fill or counter change; match=0.
- DONE: hold match_cnt. start returns to IDLE (no relaunch in the same cycle); abort also returns to IDLE.
- abort in RUN: go to IDLE next cycle. A bit accepted in the abort cycle still updates match and match_cnt. match_cnt holds until the next start.
- abort has priority over start. start while in RUN is ignored.
- Latency: match is 0-cycle (Mealy) from the accepted bit; busy and done are registered.
- len=1 is valid: every bit equal to pattern[0] matches.

Decomposition:
- Shared package seq_det_pkg holds the state encoding constants (IDLE/RUN/DONE), the default MAXLEN and the LEN_W derivation.
- One sub-module, seq_match_core: history shift register, fill counter and match compare, with accept/clear/len/pattern/overlap inputs.
- seq_det_ctrl contains the FSM, config latches and match counter.

Test Plan:
- Reset then start with pattern=3'b101, len=3, overlap=1, target=0; stream 1,0,1,0,1 with valid every cycle -> match on accepted bits 3 and 5; match_cnt=2; busy=1.
- Same stream with overlap=0 -> match only on bit 3; match_cnt=1.
- overlap=1, target=2, stream 1,0,1,0,1,1 -> match on bit 5; DONE the next cycle; din_ready=0; bit 6 not accepted; match_cnt=2; done=1.
- start with len=0, and separately len=MAXLEN+1 -> cfg_err single pulse; state_out=00; din_ready stays 0.
- din_valid toggled with gaps inside 1,0,1 -> match timing follows accepted bits only; no spurious match in idle cycles.
- abort after bits 1,0 of 101 -> IDLE next cycle, match_cnt held. Separately, drive rst low mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
